encrypted_unpack_fifo: RTL and testbench

Buffers 128-bit ciphertext blocks from the AES controller and presents them one byte at a time to the transmitter control unit. It sits directly downstream of aes_control and upstream of the TX path, via a fast-domain read strobe. The block is a first-word-fall-through FIFO with block-granular writes and byte-granular reads.

---
 rtl/usb_aes_pkg.sv | 7 +
 rtl/unpack_byte_sel.sv | 21 ++
 rtl/encrypted_unpack_fifo.sv | 116 +++++++++++
 tb/tb_encrypted_unpack_fifo.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/usb_aes_pkg.sv
// Shared AES/USB types and widths for the ciphertext unpack path.
package usb_aes_pkg;
    localparam int AES_BLK_W = 128;
    localparam int AES_BYTES = 16;
    typedef logic [127:0] aes_blk_t;
    typedef logic [7:0]   usb_byte_t;
endpackage

// File: rtl/unpack_byte_sel.sv
// Combinational byte picker from a 128-bit block.
// Order: MSB-first by default, LSB-first when UNPACK_LSB_FIRST_EN is defined.
module unpack_byte_sel
    import usb_aes_pkg::*;
(
    input  aes_blk_t   blk_i,
    input  logic [3:0] idx_i,
    output usb_byte_t  byte_o
);
    logic [6:0] base_s;

    // Bit offset of the selected byte's LSB
    always_comb begin
`ifdef UNPACK_LSB_FIRST_EN
        base_s = {idx_i, 3'b000};
`else
        base_s = 7'd120 - {idx_i, 3'b000};
`endif
        byte_o = blk_i[base_s +: 8];
    end
endmodule

// File: rtl/encrypted_unpack_fifo.sv
// Block-write / byte-read FWFT FIFO between aes_control and the TX path.
// Byte order is selected by UNPACK_LSB_FIRST_EN (see unpack_byte_sel).
module encrypted_unpack_fifo
    import usb_aes_pkg::*;
#(
    parameter int DEPTH_BLK     = 2,
    parameter int BYTES_PER_BLK = AES_BYTES
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      complete,
    input  aes_blk_t  raw_data,
    input  logic      r_enable,
    output usb_byte_t r_data,
    output logic      empty,
    output logic      full,
    output logic      blk_last,
    output logic      overflow
);
    localparam int         PTR_W    = $clog2(DEPTH_BLK);
    localparam int         CNT_W    = PTR_W + 1;
    localparam logic [3:0] LAST_IDX = 4'(BYTES_PER_BLK - 1);

    aes_blk_t          mem_q [DEPTH_BLK];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [3:0]        byte_idx_q, byte_idx_d;
    logic [CNT_W-1:0]  blk_cnt_q, blk_cnt_d;
    logic              overflow_q, overflow_d;

    logic              wr_en_s, rd_en_s, last_pop_s;
    usb_byte_t         sel_byte_s;

    assign empty    = (blk_cnt_q == CNT_W'(0));
    assign full     = (blk_cnt_q == CNT_W'(DEPTH_BLK));
    assign blk_last = !empty && (byte_idx_q == LAST_IDX);
    assign overflow = overflow_q;

    unpack_byte_sel u_sel (
        .blk_i  (mem_q[rd_ptr_q]),
        .idx_i  (byte_idx_q),
        .byte_o (sel_byte_s)
    );

    // Head byte presented only while something is buffered
    always_comb begin
        if (empty) begin
            r_data = 8'h00;
        end else begin
            r_data = sel_byte_s;
        end
    end

    // Next-state for pointers, count and sticky overflow
    always_comb begin
        wr_en_s    = complete && !full;
        rd_en_s    = r_enable && !empty;
        last_pop_s = rd_en_s && (byte_idx_q == LAST_IDX);

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (last_pop_s) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            byte_idx_d = 4'd0;
        end else if (rd_en_s) begin
            rd_ptr_d   = rd_ptr_q;
            byte_idx_d = byte_idx_q + 4'd1;
        end else begin
            rd_ptr_d   = rd_ptr_q;
            byte_idx_d = byte_idx_q;
        end

        case ({wr_en_s, last_pop_s})
            2'b10:   blk_cnt_d = blk_cnt_q + CNT_W'(1);
            2'b01:   blk_cnt_d = blk_cnt_q - CNT_W'(1);
            default: blk_cnt_d = blk_cnt_q;
        endcase

        // A pop in the same cycle does not free the slot for this write
        overflow_d = overflow_q || (complete && full);
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            byte_idx_q <= 4'd0;
            blk_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            byte_idx_q <= byte_idx_d;
            blk_cnt_q  <= blk_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Block storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH_BLK; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_s) begin
            mem_q[wr_ptr_q] <= raw_data;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end
endmodule

// File: tb/tb_encrypted_unpack_fifo.sv
// Self-checking bench: block-queue reference model plus directed literal checks.
module tb_encrypted_unpack_fifo;
    import usb_aes_pkg::*;

    localparam int DEPTH = 2;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      complete = 1'b0;
    aes_blk_t  raw_data = '0;
    logic      r_enable = 1'b0;
    usb_byte_t r_data;
    logic      empty, full, blk_last, overflow;

    int n_chk  = 0;
    int n_fail = 0;

    aes_blk_t mq[$];
    int       midx = 0;
    bit       movf = 1'b0;

    encrypted_unpack_fifo #(.DEPTH_BLK(DEPTH), .BYTES_PER_BLK(16)) dut (
        .clk(clk), .rst(rst), .complete(complete), .raw_data(raw_data),
        .r_enable(r_enable), .r_data(r_data), .empty(empty), .full(full),
        .blk_last(blk_last), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Byte i of a block in stream order
    function automatic logic [7:0] mbyte(input aes_blk_t b, input int i);
        aes_blk_t t;
`ifdef UNPACK_LSB_FIRST_EN
        t = b >> (8 * i);
`else
        t = b >> (8 * (15 - i));
`endif
        return t[7:0];
    endfunction

    // Block whose stream bytes are base, base+1, ..., base+15
    function automatic aes_blk_t mk_blk(input logic [7:0] base);
        aes_blk_t b = '0;
        for (int i = 0; i < 16; i++) begin
`ifdef UNPACK_LSB_FIRST_EN
            b = b | (aes_blk_t'(base + 8'(i)) << (8 * i));
`else
            b = b | (aes_blk_t'(base + 8'(i)) << (8 * (15 - i)));
`endif
        end
        return b;
    endfunction

    task automatic model_step(input logic c, input aes_blk_t d, input logic re);
        bit full_m  = (mq.size() == DEPTH);
        bit empty_m = (mq.size() == 0);
        if (re && !empty_m) begin
            if (midx == 15) begin
                void'(mq.pop_front());
                midx = 0;
            end else begin
                midx++;
            end
        end
        if (c) begin
            if (full_m) movf = 1'b1;
            else        mq.push_back(d);
        end
    endtask

    task automatic cycle(input logic c, input aes_blk_t d, input logic re);
        complete = c;
        raw_data = d;
        r_enable = re;
        @(posedge clk);
        model_step(c, d, re);
        #1;
        complete = 1'b0;
        r_enable = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        mq.delete();
        midx = 0;
        movf = 1'b0;
        #1;
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_rdata", 32'(r_data), 32'h00);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_last", 32'(blk_last), 32'h0);
        #1;
        rst = 1'b0;
    endtask

    // Every-cycle comparison against the reference model
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_empty", 32'(empty), 32'(mq.size() == 0));
            chk("m_full", 32'(full), 32'(mq.size() == DEPTH));
            chk("m_ovf", 32'(overflow), 32'(movf));
            chk("m_last", 32'(blk_last), 32'((mq.size() != 0) && (midx == 15)));
            chk("m_rdata", 32'(r_data), 32'((mq.size() == 0) ? 8'h00 : mbyte(mq[0], midx)));
        end
    end

    aes_blk_t blk_a;

    initial begin
`ifdef UNPACK_LSB_FIRST_EN
        blk_a = 128'h0F0E0D0C0B0A09080706050403020100;
`else
        blk_a = 128'h000102030405060708090A0B0C0D0E0F;
`endif
        #12 rst = 1'b0;
        do_reset();

        // Single block, byte-by-byte
        cycle(1'b1, blk_a, 1'b0);
        chk("t1_empty", 32'(empty), 32'h0);
        chk("t1_b0", 32'(r_data), 32'h00);
        chk("t1_last0", 32'(blk_last), 32'h0);
        for (int k = 1; k <= 15; k++) begin
            cycle(1'b0, '0, 1'b1);
            chk("t1_byte", 32'(r_data), 32'(k));
        end
        chk("t1_last15", 32'(blk_last), 32'h1);
        cycle(1'b0, '0, 1'b1);
        chk("t1_empty_end", 32'(empty), 32'h1);
        chk("t1_rdata_end", 32'(r_data), 32'h00);
        // r_enable while empty is ignored
        repeat (3) cycle(1'b0, '0, 1'b1);
        chk("t1_idle_empty", 32'(empty), 32'h1);

        // Overflow on third back-to-back write
        cycle(1'b1, mk_blk(8'h10), 1'b0);
        cycle(1'b1, mk_blk(8'h20), 1'b0);
        chk("t2_full", 32'(full), 32'h1);
        cycle(1'b1, mk_blk(8'h30), 1'b0);
        chk("t2_ovf", 32'(overflow), 32'h1);
        chk("t2_head", 32'(r_data), 32'h10);
        repeat (16) cycle(1'b0, '0, 1'b1);
        chk("t2_blk2", 32'(r_data), 32'h20);
        repeat (16) cycle(1'b0, '0, 1'b1);
        chk("t2_drained", 32'(empty), 32'h1);
        chk("t2_ovf_sticky", 32'(overflow), 32'h1);

        // Five blocks, next write lands on the last-byte pop
        cycle(1'b1, mk_blk(8'h40), 1'b0);
        for (int b = 1; b <= 5; b++) begin
            repeat (15) cycle(1'b0, '0, 1'b1);
            chk("t3_last", 32'(blk_last), 32'h1);
            if (b < 5) begin
                cycle(1'b1, mk_blk(8'(8'h40 + 8'(16 * b))), 1'b1);
                chk("t3_newhead", 32'(r_data), 32'(8'h40 + 8'(16 * b)));
                chk("t3_cnt1", 32'(full), 32'h0);
            end else begin
                cycle(1'b0, '0, 1'b1);
                chk("t3_empty", 32'(empty), 32'h1);
            end
        end

        // Reset mid-block
        cycle(1'b1, mk_blk(8'h80), 1'b0);
        repeat (7) cycle(1'b0, '0, 1'b1);
        chk("t4_mid", 32'(r_data), 32'h87);
        do_reset();
        cycle(1'b1, mk_blk(8'h90), 1'b0);
        chk("t4_restart", 32'(r_data), 32'h90);
        repeat (16) cycle(1'b0, '0, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cycle(1'($urandom_range(0, 3) == 0),
                  {$urandom, $urandom, $urandom, $urandom},
                  1'($urandom_range(0, 3) != 0));
            if ($urandom_range(0, 999) == 0) do_reset();
        end

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
